read_ctrl_sync: RTL and testbench

//  Read-domain pointer/flag controller for the async FIFO, next generation of the read-increment block.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/gray_sync.sv | 32 +++
 rtl/read_ctrl_sync.sv | 75 +++++++
 tb/tb_read_ctrl_sync.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO controllers.
// The write-side controller imports the same package, so both domains
// agree on the pointer width and on the gray encoding.
package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 4;
    localparam int PTR_W         = FIFO_ADDRSIZE + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Binary to reflected gray code
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the xor of all gray bits at or above it
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a gray-coded pointer crossing clock domains.
// Only one bit changes per step, so every captured value is either the
// old or the new pointer, never a mix.
module gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the asynchronous input through the flop chain, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/read_ctrl_sync.sv
// Read-domain pointer and flag controller for the async FIFO.
// Synchronises the write gray pointer locally, then derives empty,
// fill level, almost-empty and underflow from it. Empty is pessimistic:
// the synchronised write pointer can only lag, so empty may linger but
// never drops before data is really there.
// ADDRSIZE must match fifo_pkg::FIFO_ADDRSIZE, since the pointer helpers
// are shared with the write side at that width.
module read_ctrl_sync
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = FIFO_ADDRSIZE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signal_read,
    input  logic [ADDRSIZE:0]   graycode_wptr,
    input  logic [ADDRSIZE:0]   ae_thresh,
    output logic                empty,
    output logic                almost_empty,
    output logic [ADDRSIZE-1:0] read_address,
    output logic [ADDRSIZE:0]   graycode_rptr,
    output logic [ADDRSIZE:0]   rd_level,
    output logic                underflow
);

    ptr_t rptr_bin;
    ptr_t wptr_s;
    ptr_t wbin_s;
    ptr_t rbin_next;
    ptr_t rgray_next;
    ptr_t level_next;
    logic rd_ok;

    gray_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (clk),
        .rst (rst),
        .d   (graycode_wptr),
        .q   (wptr_s)
    );

    // Next read pointer and the fill level it leaves behind
    always_comb begin
        wbin_s     = gray2bin(wptr_s);
        rd_ok      = signal_read & ~empty;
        rbin_next  = rptr_bin + {{ADDRSIZE{1'b0}}, rd_ok};
        rgray_next = bin2gray(rbin_next);
        level_next = wbin_s - rbin_next;
    end

    // Pointer, flag and level registers, all updated from the same next pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_bin      <= '0;
            graycode_rptr <= '0;
            empty         <= 1'b1;
            almost_empty  <= 1'b1;
            rd_level      <= '0;
            underflow     <= 1'b0;
        end else begin
            rptr_bin      <= rbin_next;
            graycode_rptr <= rgray_next;
            empty         <= (rgray_next == wptr_s);
            almost_empty  <= (level_next <= ae_thresh);
            rd_level      <= level_next;
            underflow     <= signal_read & empty;
        end
    end

    assign read_address = rptr_bin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_read_ctrl_sync.sv
// Scoreboard bench for read_ctrl_sync. A behavioural model written in
// integer pointer arithmetic predicts every output per cycle; predictions
// are queued as stimulus is driven and popped once the clock edge lands.
module tb_read_ctrl_sync;

    localparam int ADDRSIZE    = 4;
    localparam int SYNC_STAGES = 2;
    localparam int PW          = ADDRSIZE + 1;
    localparam int PMOD        = 1 << PW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       signal_read = 1'b0;
    logic [4:0] graycode_wptr = '0;
    logic [4:0] ae_thresh = 5'd3;
    logic       empty;
    logic       almost_empty;
    logic [3:0] read_address;
    logic [4:0] graycode_rptr;
    logic [4:0] rd_level;
    logic       underflow;

    read_ctrl_sync #(
        .ADDRSIZE    (ADDRSIZE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .signal_read   (signal_read),
        .graycode_wptr (graycode_wptr),
        .ae_thresh     (ae_thresh),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .read_address  (read_address),
        .graycode_rptr (graycode_rptr),
        .rd_level      (rd_level),
        .underflow     (underflow)
    );

    always #100 clk = ~clk;

    typedef struct {
        logic       empty;
        logic       ae;
        logic [3:0] raddr;
        logic [4:0] rgray;
        logic [4:0] level;
        logic       uf;
    } exp_t;

    exp_t sbQueue[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   mRptr;
    int   mSync [SYNC_STAGES];
    logic mEmpty;
    logic mAe;
    logic mUf;
    int   mLevel;

    int   prevAddr;
    int   prevGray;
    int   addrWraps;
    int   lapWraps;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int toGray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int fromGray(input int g);
        int b = g;
        for (int s = 1; s < PW; s++) b = b ^ (g >> s);
        return b & (PMOD - 1);
    endfunction

    task automatic modelReset();
        mRptr = 0;
        for (int i = 0; i < SYNC_STAGES; i++) mSync[i] = 0;
        mEmpty = 1'b1;
        mAe    = 1'b1;
        mUf    = 1'b0;
        mLevel = 0;
    endtask

    // Drive one cycle of stimulus, predict, wait for the edge, compare
    task automatic applyStimulus(input logic rd, input int wbinIn, input logic rstIn, input string tag);
        exp_t e;
        int   wb;
        int   nr;
        logic ok;
        signal_read   = rd;
        graycode_wptr = 5'(toGray(wbinIn % PMOD));
        rst           = rstIn;
        if (rstIn) begin
            modelReset();
        end else begin
            wb     = fromGray(mSync[SYNC_STAGES-1]);
            ok     = rd && !mEmpty;
            nr     = (mRptr + (ok ? 1 : 0)) % PMOD;
            mUf    = rd && mEmpty;
            mLevel = (wb - nr) & (PMOD - 1);
            mEmpty = (nr == wb);
            mAe    = (mLevel <= int'(ae_thresh));
            mRptr  = nr;
            for (int i = SYNC_STAGES - 1; i > 0; i--) mSync[i] = mSync[i-1];
            mSync[0] = toGray(wbinIn % PMOD);
        end
        e.empty = mEmpty;
        e.ae    = mAe;
        e.raddr = 4'(mRptr);
        e.rgray = 5'(toGray(mRptr));
        e.level = 5'(mLevel);
        e.uf    = mUf;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        e = sbQueue.pop_front();
        checkOutput({tag, ".empty"}, 32'(empty), 32'(e.empty));
        checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(e.ae));
        checkOutput({tag, ".read_address"}, 32'(read_address), 32'(e.raddr));
        checkOutput({tag, ".graycode_rptr"}, 32'(graycode_rptr), 32'(e.rgray));
        checkOutput({tag, ".rd_level"}, 32'(rd_level), 32'(e.level));
        checkOutput({tag, ".underflow"}, 32'(underflow), 32'(e.uf));
        if (prevAddr == 15 && read_address == 4'd0) addrWraps++;
        if (prevGray == 5'b10000 && graycode_rptr == 5'b00000) lapWraps++;
        prevAddr = int'(read_address);
        prevGray = int'(graycode_rptr);
    endtask

    initial begin
        modelReset();
        prevAddr  = 0;
        prevGray  = 0;
        addrWraps = 0;
        lapWraps  = 0;

        // Reset held
        repeat (2) applyStimulus(1'b0, 0, 1'b1, "reset");
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_ae", 32'(almost_empty), 32'd1);
        checkOutput("reset_raddr", 32'(read_address), 32'd0);
        checkOutput("reset_rgray", 32'(graycode_rptr), 32'd0);
        checkOutput("reset_level", 32'(rd_level), 32'd0);

        // Ten words written, then a burst of reads and underflow
        repeat (3) applyStimulus(1'b0, 10, 1'b0, "sync");
        checkOutput("sync_level10", 32'(rd_level), 32'd10);
        checkOutput("sync_notempty", 32'(empty), 32'd0);
        repeat (10) applyStimulus(1'b1, 10, 1'b0, "burst");
        checkOutput("burst_empty", 32'(empty), 32'd1);
        checkOutput("burst_rgray", 32'(graycode_rptr), 32'b01111);
        repeat (3) applyStimulus(1'b1, 10, 1'b0, "uflow");
        checkOutput("uflow_pulse", 32'(underflow), 32'd1);
        checkOutput("uflow_hold", 32'(graycode_rptr), 32'b01111);

        // Wrap: writer advances 37 steps while reading continuously
        addrWraps = 0;
        lapWraps  = 0;
        for (int i = 1; i <= 37; i++) applyStimulus(1'b1, 10 + i, 1'b0, "wrap");
        repeat (8) applyStimulus(1'b1, 47, 1'b0, "drain");
        checkOutput("wrap_addr_count", 32'(addrWraps), 32'd2);
        checkOutput("wrap_lap_count", 32'(lapWraps), 32'd1);
        checkOutput("wrap_final_addr", 32'(read_address), 32'd15);
        checkOutput("wrap_final_empty", 32'(empty), 32'd1);

        // Almost-empty with threshold 3 and eight words
        repeat (3) applyStimulus(1'b0, 23, 1'b0, "ae_sync");
        checkOutput("ae_level8", 32'(rd_level), 32'd8);
        checkOutput("ae_clear", 32'(almost_empty), 32'd0);
        repeat (8) applyStimulus(1'b1, 23, 1'b0, "ae_read");
        checkOutput("ae_end_empty", 32'(empty), 32'd1);
        checkOutput("ae_end_flag", 32'(almost_empty), 32'd1);

        // Reset asserted between edges in the middle of a burst
        repeat (3) applyStimulus(1'b0, 31, 1'b0, "mid_sync");
        repeat (3) applyStimulus(1'b1, 31, 1'b0, "mid_read");
        #50;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_empty", 32'(empty), 32'd1);
        checkOutput("async_ae", 32'(almost_empty), 32'd1);
        checkOutput("async_raddr", 32'(read_address), 32'd0);
        checkOutput("async_rgray", 32'(graycode_rptr), 32'd0);
        checkOutput("async_level", 32'(rd_level), 32'd0);
        repeat (2) applyStimulus(1'b1, 31, 1'b1, "rst_hold");
        checkOutput("rst_hold_raddr", 32'(read_address), 32'd0);

        // Write pointer advances on the same cycle as the last read
        repeat (3) applyStimulus(1'b0, 10, 1'b0, "sim_sync");
        repeat (9) applyStimulus(1'b1, 10, 1'b0, "sim_read");
        applyStimulus(1'b1, 11, 1'b0, "sim_last");
        checkOutput("sim_last_empty", 32'(empty), 32'd1);
        checkOutput("sim_last_raddr", 32'(read_address), 32'd10);
        applyStimulus(1'b1, 11, 1'b0, "sim_wait");
        checkOutput("sim_wait_empty", 32'(empty), 32'd1);
        applyStimulus(1'b1, 11, 1'b0, "sim_seen");
        checkOutput("sim_seen_empty", 32'(empty), 32'd0);
        checkOutput("sim_seen_raddr", 32'(read_address), 32'd10);
        applyStimulus(1'b1, 11, 1'b0, "sim_11th");
        checkOutput("sim_11th_raddr", 32'(read_address), 32'd11);
        checkOutput("sim_11th_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
